// File: rtl/dds_if.sv
// DDS control and sample bundle: tuning and phase-load inputs from the master,
// registered I/Q samples back from the generator.
interface dds_if;
  logic        ena_i;
  logic [10:0] phase_i;
  logic        phase_load_i;
  logic [10:0] phase_incr_i;
  logic [8:0]  di_o;
  logic [8:0]  dq_o;

  modport master (
    output ena_i, phase_i, phase_load_i, phase_incr_i,
    input  di_o, dq_o
  );

  modport slave (
    input  ena_i, phase_i, phase_load_i, phase_incr_i,
    output di_o, dq_o
  );
endinterface

// File: rtl/dds.sv
// Quadrature DDS: 11-bit phase accumulator feeding a 512-entry quarter-wave table.
// Define DDS_PIPE_EN to add one output register stage after the table.
module dds (
  input  logic clk_i,
  input  logic rst_i,
  dds_if.slave bus
);

  localparam real HALF_PI = 1.5707963267948966;

  logic [7:0] qtab [512];

  for (genvar g = 0; g < 512; g++) begin : g_qtab
    localparam int TV = $rtoi(255.0 * $sin(HALF_PI * (real'(g) + 0.5) / 512.0) + 0.5);
    assign qtab[g] = 8'(TV);
  end

  logic [10:0] acc_q, acc_d;
  logic [8:0]  di_q, di_d;
  logic [8:0]  dq_q, dq_d;
  logic [8:0]  t_dir, t_mir;

  always_comb begin
    acc_d = acc_q;
    if (bus.phase_load_i) begin
      acc_d = bus.phase_i;
    end else if (bus.ena_i) begin
      acc_d = acc_q + bus.phase_incr_i;
    end
  end

  // Mirrored index 511-k is the bitwise complement of the 9-bit in-quadrant offset.
  assign t_dir = {1'b0, qtab[acc_q[8:0]]};
  assign t_mir = {1'b0, qtab[~acc_q[8:0]]};

  always_comb begin
    di_d = '0;
    dq_d = '0;
    case (acc_q[10:9])
      2'd0: begin di_d =  t_mir; dq_d =  t_dir; end
      2'd1: begin di_d = -t_dir; dq_d =  t_mir; end
      2'd2: begin di_d = -t_mir; dq_d = -t_dir; end
      2'd3: begin di_d =  t_dir; dq_d = -t_mir; end
      default: begin di_d = '0; dq_d = '0; end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q <= '0;
      di_q  <= '0;
      dq_q  <= '0;
    end else begin
      acc_q <= acc_d;
      di_q  <= di_d;
      dq_q  <= dq_d;
    end
  end

`ifdef DDS_PIPE_EN
  logic [8:0] di_p_q, dq_p_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      di_p_q <= '0;
      dq_p_q <= '0;
    end else begin
      di_p_q <= di_q;
      dq_p_q <= dq_q;
    end
  end

  assign bus.di_o = di_p_q;
  assign bus.dq_o = dq_p_q;
`else
  assign bus.di_o = di_q;
  assign bus.dq_o = dq_q;
`endif

endmodule

// File: tb/tb_dds.sv
// Directed bench for dds: vector table, full-circle sweep against a trig model,
// and asynchronous reset sequences.
`timescale 1ns/1ps
module tb_dds;

  localparam real PI = 3.141592653589793;
`ifdef DDS_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  dds_if bus ();

  dds dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit ld;
    int ph;
    bit en;
    int inc;
    int di;
    int dq;
  } vec_t;

  vec_t tbl [20];

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int ref_i(int acc);
    return rnd(255.0 * $cos(2.0 * PI * (real'(acc) + 0.5) / 2048.0));
  endfunction

  function automatic int ref_q(int acc);
    return rnd(255.0 * $sin(2.0 * PI * (real'(acc) + 0.5) / 2048.0));
  endfunction

  task automatic check(input string name, input int exp_di, input int exp_dq);
    int a_di;
    int a_dq;
    a_di = int'($signed(bus.di_o));
    a_dq = int'($signed(bus.dq_o));
    checks++;
    if (a_di !== exp_di || a_dq !== exp_dq) begin
      failures++;
      $display("FAIL %s: got di=%0d dq=%0d, expected di=%0d dq=%0d",
               name, a_di, a_dq, exp_di, exp_dq);
    end
  endtask

  task automatic drive(input bit ld, input int ph, input bit en, input int inc);
    bus.phase_load_i = ld;
    bus.phase_i      = 11'(ph);
    bus.ena_i        = en;
    bus.phase_incr_i = 11'(inc);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int pd, pq, ed, eq, cd, cq, m_acc;
    int hist_di [2048];
    int hist_dq [2048];

    // Expected outputs right after each edge, for the undelayed build.
    tbl[0]  = '{1'b1,  512, 1'b0,    0,  255,    0};
    tbl[1]  = '{1'b0,    0, 1'b0,    0,    0,  255};
    tbl[2]  = '{1'b0,    0, 1'b0,    0,    0,  255};
    tbl[3]  = '{1'b1, 1024, 1'b1,    5,    0,  255};
    tbl[4]  = '{1'b0,    0, 1'b0,    0, -255,    0};
    tbl[5]  = '{1'b1, 1536, 1'b0,    0, -255,    0};
    tbl[6]  = '{1'b0,    0, 1'b0,    0,    0, -255};
    tbl[7]  = '{1'b1,    0, 1'b0,    0,    0, -255};
    tbl[8]  = '{1'b0,    0, 1'b1,    0,  255,    0};
    tbl[9]  = '{1'b0,    0, 1'b1,    0,  255,    0};
    tbl[10] = '{1'b1, 2040, 1'b0,    0,  255,    0};
    tbl[11] = '{1'b0,    0, 1'b1,   16,  255,   -6};
    tbl[12] = '{1'b0,    0, 1'b1,   16,  255,    7};
    tbl[13] = '{1'b0,    0, 1'b1,   16,  254,   19};
    tbl[14] = '{1'b1,    0, 1'b0,    0,  253,   32};
    tbl[15] = '{1'b0,    0, 1'b1, 1024,  255,    0};
    tbl[16] = '{1'b0,    0, 1'b1, 1024, -255,    0};
    tbl[17] = '{1'b0,    0, 1'b1, 1024,  255,    0};
    tbl[18] = '{1'b0,    0, 1'b1, 1024, -255,    0};
    tbl[19] = '{1'b0,    0, 1'b0,    0,  255,    0};

    drive(1'b0, 0, 1'b0, 0);
    #2 rst_i = 1'b0;
    #1 check("reset_async", 0, 0);
    tick();
    tick();
    check("reset_held", 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    check("reset_edge1", PIPE ? 0 : 255, 0);
    tick();
    check("reset_edge2", 255, 0);

    pd = 255;
    pq = 0;
    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].ld, tbl[r].ph, tbl[r].en, tbl[r].inc);
      tick();
      ed = PIPE ? pd : tbl[r].di;
      eq = PIPE ? pq : tbl[r].dq;
      check($sformatf("vec%0d", r), ed, eq);
      pd = tbl[r].di;
      pq = tbl[r].dq;
    end

    m_acc = 0;
    pd = ref_i(0);
    pq = ref_q(0);
    drive(1'b0, 0, 1'b1, 1);
    for (int n = 0; n < 2048 + 16; n++) begin
      cd = ref_i(m_acc);
      cq = ref_q(m_acc);
      ed = PIPE ? pd : cd;
      eq = PIPE ? pq : cq;
      pd = cd;
      pq = cq;
      m_acc = (m_acc + 1) % 2048;
      tick();
      check($sformatf("sweep%0d", n), ed, eq);
      if (n < 2048) begin
        hist_di[n] = int'($signed(bus.di_o));
        hist_dq[n] = int'($signed(bus.dq_o));
      end else begin
        check($sformatf("period%0d", n), hist_di[n - 2048], hist_dq[n - 2048]);
      end
    end

    drive(1'b0, 0, 1'b1, 100);
    #2 rst_i = 1'b0;
    #1 check("reset_midop_async", 0, 0);
    tick();
    check("reset_midop_held", 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    check("reset_midop_edge1", PIPE ? 0 : 255, 0);
    tick();
    check("reset_midop_edge2", PIPE ? 255 : ref_i(100), PIPE ? 0 : ref_q(100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
